// File: rtl/uart_fb_pkg.sv
// Shared types, defaults and address-width helper for the UART-to-frame-buffer loader.
package uart_fb_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_e;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 200;
  localparam int PIX_W_DEF = 3;
  localparam int RX_W_DEF  = 4;

  function automatic int FB_ADDR_W(input int img_w, input int img_h);
    return $clog2(img_w * img_h);
  endfunction

endpackage

// File: rtl/uart_frame_loader_rdy_edge_det.sv
// Rising-edge detector on the receiver's symbol-held level; the history flop resets high
// so a symbol already held when reset releases never produces an event.
module rdy_edge_det
  import uart_fb_pkg::*;
(
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic rx_ready,
  output logic rdy_rise
);

  logic rx_ready_q;
  logic rx_ready_d;

  always_comb begin
    rx_ready_d = rx_ready;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) rx_ready_q <= 1'b1;
    else         rx_ready_q <= rx_ready_d;
  end

  assign rdy_rise = rx_ready & ~rx_ready_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Turns received UART symbols into linear frame-buffer pixel writes, one per rx_ready edge.
// Optional LOADER_SKIP_INVALID_EN: drop symbols failing the framing check and count them.
module uart_frame_loader
  import uart_fb_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int RX_W   = RX_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = FB_ADDR_W(IMG_W, IMG_H)
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              rearm,
  input  logic              rx_ready,
  input  logic              rx_valid,
  input  logic [RX_W-1:0]   rx_data,
  output logic              rx_start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  loader_state_e     state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              rx_start_q, rx_start_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              rdy_rise;
  logic              accept;

  // Not every build reads rx_valid or the low symbol bits.
  logic unused_inputs;
  assign unused_inputs = ^{rx_valid, rx_data};

  rdy_edge_det u_rdy_edge_det (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .rx_ready (rx_ready),
    .rdy_rise (rdy_rise)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    idx_d        = idx_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = frame_done_q;
    err_cnt_d    = err_cnt_q;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        col_d   = '0;
        row_d   = '0;
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
`ifdef LOADER_SKIP_INVALID_EN
        if (rdy_rise && !rx_valid) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (rdy_rise) begin
          accept = 1'b1;
        end
`else
        if (rdy_rise) accept = 1'b1;
`endif
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = rx_data[RX_W-1 -: PIX_W];
          // The linear index runs alongside col/row so no row*IMG_W product is needed.
          idx_d     = idx_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
              state_d      = DONE;
              frame_done_d = 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (rearm) begin
          frame_done_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_start_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      rx_start_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      rx_start_q   <= rx_start_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rx_start   = rx_start_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench: a 4x2 loader for the functional cases and a default-size loader for a full frame.
module tb_uart_frame_loader;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Small 4x2 instance
  logic       resetn, rearm, rx_ready, rx_valid;
  logic [3:0] rx_data;
  logic       rx_start, wr_en, frame_done, busy;
  logic [2:0] wr_addr, wr_data;
  logic [7:0] err_cnt;

  uart_frame_loader #(.IMG_W(4), .IMG_H(2), .RX_W(4), .PIX_W(3), .ADDR_W(3)) dut (
    .CLOCK_50(clk), .resetn(resetn), .rearm(rearm), .rx_ready(rx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_start(rx_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .busy(busy),
    .err_cnt(err_cnt)
  );

  // Default-parameter instance
  logic        resetn_b, rearm_b, rx_ready_b, rx_valid_b;
  logic [3:0]  rx_data_b;
  logic        rx_start_b, wr_en_b, frame_done_b, busy_b;
  logic [14:0] wr_addr_b;
  logic [2:0]  wr_data_b;
  logic [7:0]  err_cnt_b;

  uart_frame_loader dut_b (
    .CLOCK_50(clk), .resetn(resetn_b), .rearm(rearm_b), .rx_ready(rx_ready_b),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_start(rx_start_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .frame_done(frame_done_b), .busy(busy_b),
    .err_cnt(err_cnt_b)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fd;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_qb[$];
  int  checks = 0;
  int  errors = 0;

  int  m_idx  = 0;
  bit  m_done = 1'b0;
  int  m_err  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("wr_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_val("wr_addr", 32'(wr_addr), e.addr);
        check_val("wr_data", 32'(wr_data), e.data);
        check_val("wr_frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  always @(negedge clk) begin
    if (wr_en_b === 1'b1) begin
      if (exp_qb.size() == 0) begin
        check_val("b_wr_pending", 32'(exp_qb.size()), 32'd1);
      end else begin
        wr_t e;
        e = exp_qb.pop_front();
        check_val("b_wr_addr", 32'(wr_addr_b), e.addr);
        check_val("b_wr_data", 32'(wr_data_b), e.data);
        check_val("b_wr_frame_done", 32'(frame_done_b), 32'(e.fd));
      end
    end
  end

  task automatic send_s(input logic [3:0] d, input bit v, input int hold);
    bit wr;
    @(negedge clk);
    rx_data  = d;
    rx_valid = v;
    rx_ready = 1'b1;
    wr = !m_done;
`ifdef LOADER_SKIP_INVALID_EN
    if (wr && !v) begin
      wr = 1'b0;
      if (m_err < 255) m_err++;
    end
`endif
    if (wr) begin
      exp_q.push_back('{addr: 32'(m_idx), data: 32'(d >> 1), fd: (m_idx == 7)});
      m_idx++;
      if (m_idx == 8) m_done = 1'b1;
    end
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_b(input logic [3:0] d, input int idx);
    @(negedge clk);
    rx_data_b  = d;
    rx_ready_b = 1'b1;
    if (idx < 32000)
      exp_qb.push_back('{addr: 32'(idx), data: 32'(d >> 1), fd: (idx == 31999)});
    @(negedge clk);
    rx_ready_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_rx_start"},   32'(rx_start),   32'd0);
    check_val({pfx, "_wr_en"},      32'(wr_en),      32'd0);
    check_val({pfx, "_wr_addr"},    32'(wr_addr),    32'd0);
    check_val({pfx, "_wr_data"},    32'(wr_data),    32'd0);
    check_val({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
    check_val({pfx, "_busy"},       32'(busy),       32'd0);
    check_val({pfx, "_err_cnt"},    32'(err_cnt),    32'd0);
  endtask

  initial begin
    resetn = 1'b0; rearm = 1'b0; rx_ready = 1'b0; rx_valid = 1'b1; rx_data = 4'h0;
    resetn_b = 1'b0; rearm_b = 1'b0; rx_ready_b = 1'b0; rx_valid_b = 1'b1; rx_data_b = 4'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    resetn = 1'b1;
    resetn_b = 1'b1;
    @(negedge clk);
    check_val("load_rx_start", 32'(rx_start), 32'd1);
    check_val("load_busy",     32'(busy),     32'd1);

    // Full 4x2 frame: symbols 0x0,0x2,..,0xE -> data 0..7 at addr 0..7
    for (int i = 0; i < 8; i++) send_s(4'(2 * i), 1'b1, 1);
    check_val("done_frame_done", 32'(frame_done), 32'd1);
    check_val("done_rx_start",   32'(rx_start),   32'd0);
    check_val("done_busy",       32'(busy),       32'd0);

    // Events in DONE are ignored; an unexpected write is caught by the monitor
    for (int i = 0; i < 3; i++) send_s(4'h5, 1'b1, 1);
    check_val("done_hold_frame_done", 32'(frame_done), 32'd1);

    // Re-arm
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check_val("rearm_t1_rx_start",   32'(rx_start),   32'd0);
    check_val("rearm_t1_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    check_val("rearm_t2_rx_start",   32'(rx_start),   32'd1);
    m_idx = 0; m_done = 1'b0;
    send_s(4'h6, 1'b1, 1);

    // Held rx_ready gives a single write
    send_s(4'h4, 1'b1, 5);

    // Invalid symbol followed by a valid one
    send_s(4'h8, 1'b0, 1);
    send_s(4'hA, 1'b1, 1);
    check_val("err_cnt", 32'(err_cnt), 32'(m_err));

    // Reset mid-frame with a symbol held across reset release
    @(negedge clk);
    resetn = 1'b0;
    rx_ready = 1'b1; rx_data = 4'hE; rx_valid = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    resetn = 1'b1;
    m_idx = 0; m_done = 1'b0; m_err = 0;
    repeat (4) @(negedge clk);
    check_val("midrst_busy", 32'(busy), 32'd1);
    rx_ready = 1'b0;
    @(negedge clk);
    send_s(4'hC, 1'b1, 1);
    for (int i = 1; i < 8; i++) send_s(4'((3 * i) & 15), 1'b1, 1);
    check_val("frame2_done", 32'(frame_done), 32'd1);

    // Default-size frame, 1-cycle gap between events
    for (int i = 0; i < 32000; i++) send_b(4'($urandom_range(0, 15)), i);
    send_b(4'h9, 32000);
    check_val("b_frame_done", 32'(frame_done_b), 32'd1);
    check_val("b_rx_start",   32'(rx_start_b),   32'd0);
    check_val("b_last_addr",  32'(wr_addr_b),    32'd31999);
    check_val("b_err_cnt",    32'(err_cnt_b),    32'd0);

    repeat (3) @(negedge clk);
    check_val("sb_empty",   32'(exp_q.size()),  32'd0);
    check_val("sb_b_empty", 32'(exp_qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
